// File: rtl/mem_responder_rv.sv
// Memory-side responder for the RV core: word RAM, two combinational read ports, byte-strobed store port, MMIO, boot loader.
// Latency: reads are combinational; stores, loader writes and MMIO side effects land on the next posedge.
// Backpressure: loader bytes are accepted only in LOAD (owLoadReady); core stores have no backpressure and are ignored outside RUN.
module mem_responder_rv #(
  parameter int          ADDR_WIDTH = 12,
  parameter logic [31:0] MMIO_BASE  = 32'hFFFF0000
) (
  input  logic        iwClk,
  input  logic        iwRst,
  input  logic [31:0] iwRead1Addr,
  output logic [31:0] owRead1Data,
  input  logic [31:0] iwRead2Addr,
  output logic [31:0] owRead2Data,
  input  logic [31:0] iwWriteAddr,
  input  logic [31:0] iwWriteData,
  input  logic [3:0]  iwWstrb,
  input  logic        iwLoadValid,
  input  logic [7:0]  iwLoadByte,
  input  logic        iwLoadDone,
  output logic        owLoadReady,
  output logic        owCoreRstN,
  output logic        owConsoleValid,
  output logic [7:0]  owConsoleByte,
  output logic        owMisaligned
);

  typedef enum logic [1:0] {ST_LOAD, ST_FLUSH, ST_RUN} state_t;

  localparam logic [31:0] MMIO_LAST = MMIO_BASE + 32'd7;
  localparam logic [31:0] MMIO_CNT  = MMIO_BASE + 32'd4;

  state_t                  state, state_nxt;
  logic [31:0]             shift_q;
  logic [1:0]              cnt_q;
  logic [ADDR_WIDTH-1:0]   ld_addr_q;
  logic [31:0]             cyc_q;
  logic                    core_rst_n_q;
  logic                    cons_vld_q;
  logic [7:0]              cons_byte_q;
  logic                    mis_q;

  logic [31:0]             mem [0:(1<<ADDR_WIDTH)-1];

  logic                    load_acc;
  logic                    st_we, st_mis, cons_wr;
  logic [3:0]              st_mask;
  logic [31:0]             st_wdata;
  logic                    mem_we;
  logic [ADDR_WIDTH-1:0]   mem_addr;
  logic [31:0]             mem_wdata;
  logic [3:0]              mem_mask;
  logic [1:0]              lane;

  function automatic logic in_mmio(input logic [31:0] a);
    return (a >= MMIO_BASE) && (a <= MMIO_LAST);
  endfunction

  // Read ports never stall; MMIO addresses shadow the RAM alias they would otherwise hit.
  assign owRead1Data = in_mmio(iwRead1Addr) ? 32'h0000_0013 : mem[iwRead1Addr[ADDR_WIDTH+1:2]];
  assign owRead2Data = in_mmio(iwRead2Addr) ? ((iwRead2Addr >= MMIO_CNT) ? cyc_q : 32'd0)
                                            : mem[iwRead2Addr[ADDR_WIDTH+1:2]];

  assign owLoadReady    = (state == ST_LOAD);
  assign owCoreRstN     = core_rst_n_q;
  assign owConsoleValid = cons_vld_q;
  assign owConsoleByte  = cons_byte_q;
  assign owMisaligned   = mis_q;

  assign load_acc = (state == ST_LOAD) && iwLoadValid;
  assign lane     = iwWriteAddr[1:0];

  // FSM state register.
  always_ff @(posedge iwClk or posedge iwRst) begin
    if (iwRst) state <= ST_LOAD;
    else       state <= state_nxt;
  end

  // Next state: LOAD until the image ends, one FLUSH cycle, then RUN until reset.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_LOAD:  if (iwLoadDone) state_nxt = ST_FLUSH;
      ST_FLUSH: state_nxt = ST_RUN;
      ST_RUN:   state_nxt = ST_RUN;
      default:  state_nxt = ST_LOAD;
    endcase
  end

  // Core store decode: steer right-justified data onto byte lanes, flag misaligned half/word, catch console writes.
  always_comb begin
    st_we    = 1'b0;
    st_mis   = 1'b0;
    cons_wr  = 1'b0;
    st_mask  = 4'b0000;
    st_wdata = 32'd0;
    if (state == ST_RUN && iwWstrb != 4'b0000) begin
      if (in_mmio(iwWriteAddr)) begin
        cons_wr = (iwWriteAddr == MMIO_BASE);
      end else begin
        case (iwWstrb)
          4'b0001: begin
            st_we    = 1'b1;
            st_mask  = 4'b0001 << lane;
            st_wdata = {4{iwWriteData[7:0]}};
          end
          4'b0011: begin
            if (lane[0]) begin
              st_mis = 1'b1;
            end else begin
              st_we    = 1'b1;
              st_mask  = 4'b0011 << lane;
              st_wdata = {2{iwWriteData[15:0]}};
            end
          end
          4'b1111: begin
            if (lane != 2'b00) begin
              st_mis = 1'b1;
            end else begin
              st_we    = 1'b1;
              st_mask  = 4'b1111;
              st_wdata = iwWriteData;
            end
          end
          default: ;
        endcase
      end
    end
  end

  // Single RAM write port shared by loader (LOAD/FLUSH) and core stores (RUN).
  always_comb begin
    mem_we    = 1'b0;
    mem_addr  = ld_addr_q;
    mem_wdata = 32'd0;
    mem_mask  = 4'b1111;
    case (state)
      ST_LOAD: begin
        mem_we    = load_acc && (cnt_q == 2'd3);
        mem_wdata = {iwLoadByte, shift_q[23:0]};
      end
      ST_FLUSH: begin
        mem_we    = (cnt_q != 2'd0);
        mem_wdata = shift_q;
      end
      ST_RUN: begin
        mem_we    = st_we;
        mem_addr  = iwWriteAddr[ADDR_WIDTH+1:2];
        mem_wdata = st_wdata;
        mem_mask  = st_mask;
      end
      default: ;
    endcase
  end

  // RAM array: byte-masked write, contents survive reset.
  always_ff @(posedge iwClk) begin
    if (mem_we) begin
      for (int b = 0; b < 4; b++) begin
        if (mem_mask[b]) mem[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
      end
    end
  end

  // Loader assembly, cycle counter, console register, sticky misalignment, registered core reset release.
  always_ff @(posedge iwClk or posedge iwRst) begin
    if (iwRst) begin
      shift_q      <= 32'd0;
      cnt_q        <= 2'd0;
      ld_addr_q    <= '0;
      cyc_q        <= 32'd0;
      core_rst_n_q <= 1'b0;
      cons_vld_q   <= 1'b0;
      cons_byte_q  <= 8'd0;
      mis_q        <= 1'b0;
    end else begin
      core_rst_n_q <= (state_nxt == ST_RUN);
      cons_vld_q   <= cons_wr;
      if (cons_wr) cons_byte_q <= iwWriteData[7:0];
      if (st_mis) mis_q <= 1'b1;
      if (state == ST_RUN) cyc_q <= cyc_q + 32'd1;
      if (load_acc) begin
        if (cnt_q == 2'd3) begin
          shift_q   <= 32'd0;
          cnt_q     <= 2'd0;
          ld_addr_q <= ld_addr_q + 1'b1;
        end else begin
          shift_q[{cnt_q, 3'b000} +: 8] <= iwLoadByte;
          cnt_q <= cnt_q + 2'd1;
        end
      end
    end
  end

endmodule
